// File: rtl/m_lsu_ctrl.sv
// M-stage load/store controller: drives a req/gnt/rvalid data-memory port,
// stalls the pipeline while an access is in flight and extends load results.
module m_lsu_ctrl #(
    parameter int DW              = 32,
    parameter int ADDR_W          = 32,
    parameter int ALLOW_UNALIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic              busy,
    output logic              done,
    output logic [DW-1:0]     rdata,
    output logic              addr_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DW/8-1:0]   mem_be,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DW-1:0]     mem_rdata
);
    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE, S_ERR
    } state_t;

    state_t              state_q;
    logic                done_q, addr_err_q, mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [NB-1:0]       mem_be_q;
    logic [DW-1:0]       mem_wdata_q, rdata_q, wdata_q, buf_q;
    logic                we_q, uns_q, split_q;
    logic [4:0]          bytes_q;
    logic [OW-1:0]       off_q;

    // Byte-lane enables spanning two consecutive bus words.
    function automatic logic [2*NB-1:0] f_be(input logic [4:0] o, input logic [4:0] b);
        logic [2*NB-1:0] m;
        m = {(2*NB){1'b0}};
        for (int k = 0; k < 2*NB; k++) begin
            m[k] = (5'(k) >= o) && (5'(k) < (o + b));
        end
        return m;
    endfunction

    function automatic logic [DW-1:0] f_ext(input logic [DW-1:0] v, input logic [4:0] b,
                                            input logic u);
        logic [DW-1:0] r;
        for (int k = 0; k < DW; k++) begin
            if (k >= 8*int'(b)) begin
                r[k] = u ? 1'b0 : v[8*int'(b)-1];
            end else begin
                r[k] = v[k];
            end
        end
        return r;
    endfunction

    logic [1:0]      size_eff_s;
    logic [4:0]      bytes_s, off_ext_s, sel_off_s, sel_bytes_s;
    logic [OW-1:0]   off_s, sel_off_n_s;
    logic            misaligned_s, split_s, reject_s;
    logic [2*NB-1:0] be_s;
    logic [2*DW-1:0] wfull_s;
    logic [DW-1:0]   sel_wdata_s, ld_hi_s, ld_lo_s, ld_raw_s, ld_ext_s;

    assign size_eff_s   = (req_size == 2'd3 && DW != 64) ? 2'd2 : req_size;
    assign bytes_s      = 5'd1 << size_eff_s;
    assign off_s        = req_addr[OW-1:0];
    assign off_ext_s    = {{(5-OW){1'b0}}, off_s};
    assign misaligned_s = (off_ext_s & (bytes_s - 5'd1)) != 5'd0;
    assign split_s      = (off_ext_s + bytes_s) > 5'(NB);
    assign reject_s     = misaligned_s && (ALLOW_UNALIGNED == 0);

    // Beat-0 lanes come from the live request, beat-1 lanes from the latched one.
    assign sel_off_n_s = (state_q == S_IDLE) ? off_s : off_q;
    assign sel_off_s   = {{(5-OW){1'b0}}, sel_off_n_s};
    assign sel_bytes_s = (state_q == S_IDLE) ? bytes_s : bytes_q;
    assign sel_wdata_s = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign be_s        = f_be(sel_off_s, sel_bytes_s);
    assign wfull_s     = {{DW{1'b0}}, sel_wdata_s} << {sel_off_n_s, 3'b000};

    assign ld_hi_s  = (state_q == S_WAIT1) ? mem_rdata : {DW{1'b0}};
    assign ld_lo_s  = (state_q == S_WAIT1) ? buf_q : mem_rdata;
    assign ld_raw_s = DW'({ld_hi_s, ld_lo_s} >> {off_q, 3'b000});
    assign ld_ext_s = f_ext(ld_raw_s, bytes_q, uns_q);

    assign busy = ((state_q == S_IDLE) && req_valid && !reject_s) ||
                  (state_q == S_REQ0) || (state_q == S_WAIT0) ||
                  (state_q == S_REQ1) || (state_q == S_WAIT1);

    // Access sequencer with registered memory-side and pipeline-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            addr_err_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_be_q    <= {NB{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            rdata_q     <= {DW{1'b0}};
            wdata_q     <= {DW{1'b0}};
            buf_q       <= {DW{1'b0}};
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            split_q     <= 1'b0;
            bytes_q     <= 5'd0;
            off_q       <= {OW{1'b0}};
        end else begin
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && reject_s) begin
                        addr_err_q <= 1'b1;
                        state_q    <= S_ERR;
                    end else if (req_valid) begin
                        we_q        <= req_we;
                        uns_q       <= req_unsigned;
                        split_q     <= split_s;
                        bytes_q     <= bytes_s;
                        off_q       <= off_s;
                        wdata_q     <= req_wdata;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= req_we;
                        mem_addr_q  <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                        mem_be_q    <= be_s[NB-1:0];
                        mem_wdata_q <= wfull_s[DW-1:0];
                        state_q     <= S_REQ0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_REQ0, S_REQ1: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= (state_q == S_REQ0) ? S_WAIT0 : S_WAIT1;
                    end else begin
                        state_q <= state_q;
                    end
                end
                S_WAIT0: begin
                    if (mem_rvalid && split_q) begin
                        buf_q       <= mem_rdata;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(NB);
                        mem_be_q    <= be_s[2*NB-1:NB];
                        mem_wdata_q <= wfull_s[2*DW-1:DW];
                        state_q     <= S_REQ1;
                    end else if (mem_rvalid) begin
                        buf_q   <= mem_rdata;
                        rdata_q <= we_q ? {DW{1'b0}} : ld_ext_s;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_WAIT0;
                    end
                end
                S_WAIT1: begin
                    if (mem_rvalid) begin
                        rdata_q <= we_q ? {DW{1'b0}} : ld_ext_s;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_WAIT1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done      = done_q;
    assign addr_err  = addr_err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_m_lsu_ctrl.sv
// Bench for m_lsu_ctrl: a byte-addressed memory model drives the bus and
// predicts beats and load results; a strict instance covers rejection.
module tb_m_lsu_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        busy, done, addr_err, mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        s_req_valid, s_req_we, s_req_unsigned;
    logic [1:0]  s_req_size;
    logic [31:0] s_req_addr, s_req_wdata;
    logic        s_busy, s_done, s_addr_err, s_mem_req, s_mem_we, s_mem_gnt, s_mem_rvalid;
    logic [31:0] s_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;
    logic [3:0]  s_mem_be;

    m_lsu_ctrl #(.DW(32), .ADDR_W(32), .ALLOW_UNALIGNED(1)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .done(done), .rdata(rdata),
        .addr_err(addr_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

    m_lsu_ctrl #(.DW(32), .ADDR_W(32), .ALLOW_UNALIGNED(0)) u_strict (
        .clk(clk), .reset(reset), .req_valid(s_req_valid), .req_we(s_req_we),
        .req_size(s_req_size), .req_unsigned(s_req_unsigned), .req_addr(s_req_addr),
        .req_wdata(s_req_wdata), .busy(s_busy), .done(s_done), .rdata(s_rdata),
        .addr_err(s_addr_err), .mem_req(s_mem_req), .mem_we(s_mem_we),
        .mem_addr(s_mem_addr), .mem_be(s_mem_be), .mem_wdata(s_mem_wdata),
        .mem_gnt(s_mem_gnt), .mem_rvalid(s_mem_rvalid), .mem_rdata(s_mem_rdata));

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [0:255];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int l = 0; l < 4; l++) m[8*l +: 8] = be[l] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] w);
        return {mem[w[7:0] + 8'd3], mem[w[7:0] + 8'd2], mem[w[7:0] + 8'd1], mem[w[7:0]]};
    endfunction

    // One access on the main instance; expectations come from byte-level rules.
    task automatic do_access(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input bit lit_en, input logic [3:0] lit_be,
                             input logic [31:0] lit_wdata, input logic [31:0] lit_rdata);
        int          bytes, nbeats, gd, rd;
        logic [31:0] w0, w1, w, a, exp_rd;
        logic [31:0] b_addr [2];
        logic [3:0]  b_be   [2];
        logic [31:0] b_wd   [2];
        bytes  = (sz == 2'd3) ? 4 : (1 << sz);
        w0     = addr & ~32'h3;
        w1     = (addr + 32'(bytes) - 32'd1) & ~32'h3;
        nbeats = (w1 != w0) ? 2 : 1;
        for (int b = 0; b < 2; b++) begin
            w = (b == 0) ? w0 : w1;
            b_addr[b] = w;
            b_be[b]   = 4'h0;
            b_wd[b]   = 32'h0;
            for (int l = 0; l < 4; l++) begin
                a = w + 32'(l);
                if (a >= addr && a < addr + 32'(bytes)) begin
                    b_be[b][l] = 1'b1;
                    b_wd[b][8*l +: 8] = wd[8*int'(a - addr) +: 8];
                end
            end
        end
        exp_rd = 32'h0;
        if (!we) begin
            for (int k = 0; k < bytes; k++) exp_rd[8*k +: 8] = mem[int'(addr) + k];
            if (!uns && bytes < 4 && exp_rd[8*bytes-1]) begin
                for (int k = 8*bytes; k < 32; k++) exp_rd[k] = 1'b1;
            end
        end

        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        #1;
        chk("busy_on_request", {63'd0, busy}, 64'd1);
        tick();
        for (int b = 0; b < nbeats; b++) begin
            gd = $urandom_range(0, 3);
            for (int j = 0; j <= gd; j++) begin
                chk("mem_req_held", {63'd0, mem_req}, 64'd1);
                chk("mem_addr", {32'd0, mem_addr}, {32'd0, b_addr[b]});
                chk("mem_be", {60'd0, mem_be}, {60'd0, b_be[b]});
                chk("mem_we", {63'd0, mem_we}, {63'd0, we});
                if (we) chk("mem_wdata", {32'd0, mem_wdata & lane_mask(b_be[b])}, {32'd0, b_wd[b]});
                chk("busy_req", {63'd0, busy}, 64'd1);
                chk("done_req", {63'd0, done}, 64'd0);
                if (lit_en && b == 0 && j == 0) begin
                    chk("lit_mem_be", {60'd0, mem_be}, {60'd0, lit_be});
                    if (we) chk("lit_mem_wdata", {32'd0, mem_wdata}, {32'd0, lit_wdata});
                end
                mem_gnt    = (j == gd);
                mem_rvalid = (j == gd) && ($urandom_range(0, 1) == 1);
                mem_rdata  = $urandom;
                tick();
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            rd = $urandom_range(0, 3);
            for (int j = 0; j <= rd; j++) begin
                chk("mem_req_wait", {63'd0, mem_req}, 64'd0);
                chk("busy_wait", {63'd0, busy}, 64'd1);
                chk("done_wait", {63'd0, done}, 64'd0);
                if (j == rd) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(b_addr[b]);
                end
                tick();
            end
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("busy_done", {63'd0, busy}, 64'd0);
        chk("addr_err_done", {63'd0, addr_err}, 64'd0);
        chk("rdata", {32'd0, rdata}, {32'd0, exp_rd});
        if (lit_en) chk("lit_rdata", {32'd0, rdata}, {32'd0, lit_rdata});
        if (we) begin
            for (int k = 0; k < bytes; k++) mem[int'(addr) + k] = wd[8*k +: 8];
        end
        req_valid = 1'b0;
        tick();
        chk("done_cleared", {63'd0, done}, 64'd0);
        chk("busy_idle", {63'd0, busy}, 64'd0);
        chk("mem_req_idle", {63'd0, mem_req}, 64'd0);
    endtask

    logic [1:0]  rej_sz   [3] = '{2'd2, 2'd1, 2'd2};
    logic [31:0] rej_addr [3] = '{32'h6, 32'h1, 32'h2};

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        s_req_valid = 1'b0; s_req_we = 1'b0; s_req_size = 2'd0; s_req_unsigned = 1'b0;
        s_req_addr = 32'h0; s_req_wdata = 32'h0;
        s_mem_gnt = 1'b0; s_mem_rvalid = 1'b0; s_mem_rdata = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        tick();
        tick();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_addr_err", {63'd0, addr_err}, 64'd0);
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mem_be", {60'd0, mem_be}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("rst_s_mem_req", {63'd0, s_mem_req}, 64'd0);
        reset = 1'b0;
        tick();

        // Strict instance: aligned word load with minimum latency.
        s_req_valid = 1'b1; s_req_size = 2'd2; s_req_addr = 32'h10;
        #1;
        chk("s_busy_c0", {63'd0, s_busy}, 64'd1);
        tick();
        chk("s_mem_req_c1", {63'd0, s_mem_req}, 64'd1);
        chk("s_mem_addr_c1", {32'd0, s_mem_addr}, 64'h10);
        chk("s_mem_be_c1", {60'd0, s_mem_be}, 64'hF);
        chk("s_busy_c1", {63'd0, s_busy}, 64'd1);
        s_mem_gnt = 1'b1;
        tick();
        s_mem_gnt = 1'b0;
        chk("s_busy_c2", {63'd0, s_busy}, 64'd1);
        chk("s_mem_req_c2", {63'd0, s_mem_req}, 64'd0);
        s_mem_rvalid = 1'b1; s_mem_rdata = 32'hDEADBEEF;
        tick();
        s_mem_rvalid = 1'b0;
        chk("s_done_c3", {63'd0, s_done}, 64'd1);
        chk("s_rdata_c3", {32'd0, s_rdata}, 64'hDEADBEEF);
        chk("s_busy_c3", {63'd0, s_busy}, 64'd0);
        s_req_valid = 1'b0;
        tick();
        chk("s_done_c4", {63'd0, s_done}, 64'd0);

        // Strict instance: misaligned requests are rejected without bus traffic.
        for (int r = 0; r < 3; r++) begin
            s_req_valid = 1'b1; s_req_size = rej_sz[r]; s_req_addr = rej_addr[r];
            #1;
            chk("s_rej_busy_c0", {63'd0, s_busy}, 64'd0);
            tick();
            chk("s_rej_addr_err", {63'd0, s_addr_err}, 64'd1);
            chk("s_rej_done", {63'd0, s_done}, 64'd0);
            chk("s_rej_mem_req", {63'd0, s_mem_req}, 64'd0);
            chk("s_rej_busy_c1", {63'd0, s_busy}, 64'd0);
            s_req_valid = 1'b0;
            for (int c = 0; c < 3; c++) begin
                tick();
                chk("s_rej_quiet_req", {63'd0, s_mem_req}, 64'd0);
                chk("s_rej_quiet_err", {63'd0, s_addr_err}, 64'd0);
                chk("s_rej_quiet_busy", {63'd0, s_busy}, 64'd0);
            end
        end

        // Main instance: hand-computed cases.
        do_access(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, 1'b1, 4'b1000, 32'hAB000000, 32'h0);
        chk("store_byte_mem", {56'd0, mem[8'h13]}, 64'hAB);
        {mem[3], mem[2], mem[1], mem[0]} = 32'h80011234;
        do_access(1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 1'b1, 4'b1100, 32'h0, 32'hFFFF8001);
        do_access(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 1'b1, 4'b1100, 32'h0, 32'h00008001);
        {mem[7], mem[6], mem[5], mem[4]}   = 32'h33440000;
        {mem[11], mem[10], mem[9], mem[8]} = 32'h00001122;
        do_access(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1'b1, 4'b1100, 32'h0, 32'h11223344);

        // Stalled grant, then reset while waiting for read data.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h20; req_unsigned = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("stall_mem_req", {63'd0, mem_req}, 64'd1);
            chk("stall_mem_addr", {32'd0, mem_addr}, 64'h20);
            chk("stall_mem_be", {60'd0, mem_be}, 64'hF);
            chk("stall_busy", {63'd0, busy}, 64'd1);
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("wait0_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1; req_valid = 1'b0;
        tick();
        reset = 1'b0;
        chk("post_rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_rvalid = 1'b0;
        chk("late_rvalid_done", {63'd0, done}, 64'd0);
        tick();
        chk("late_rvalid_done2", {63'd0, done}, 64'd0);
        chk("late_rvalid_req", {63'd0, mem_req}, 64'd0);

        // Randomized accesses of every size, alignment and direction.
        for (int t = 0; t < 300; t++) begin
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 32'($urandom_range(0, 247)),
                      $urandom, 1'b0, 4'h0, 32'h0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
